pipe_wall_elastic: RTL and testbench
====================================

# pipe_wall_elastic

Parametrised elastic pipeline-stage register, the generalised successor to the fixed EX/MEM-style walls in the pipelined RISC-V core. It carries a control field and a data payload between two stages under a valid/ready handshake. It supports stall by back-pressure, flush to a bubble, and an optional two-entry skid buffer so that `in_ready` is registered. Any stage boundary of the core (F/D, D/E, E/M, M/W) instantiates it with its own widths.

## Interface
Parameters:
- `CTRL_W`, 4: width of the control field (e.g. reg_wr, mem_wr, res_src). This field is forced to zero in bubbles.
- `DATA_W`, 133: width of the data payload (e.g. alu_res, wd, pc_plus4, imm, rd).
- `SKID`, 1: 1 selects a two-entry skid buffer with registered `in_ready`. 0 selects a single register with combinational `in_ready`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset. It is synchronous and active-low.
- `flush`  in  1  synchronous flush; discards all held entries.
- `in_valid`  in  1  upstream presents an entry.
- `in_ready`  out  1  the stage accepts an entry this cycle.
- `in_ctrl`  in  CTRL_W  upstream control field.
- `in_data`  in  DATA_W  upstream payload.
- `out_valid`  out  1  the head entry is valid.
- `out_ready`  in  1  downstream consumes the head entry this cycle.
- `out_ctrl`  out  CTRL_W  head control field; all zero whenever `out_valid`=0.
- `out_data`  out  DATA_W  head payload.
- `occupancy`  out  2  number of held entries (0..2; max 1 when SKID=0).

## Operation
- Transfer rules:
  - in-fire = `in_valid` & `in_ready`.
  - out-fire = `out_valid` & `out_ready`.
  - No entry is ever dropped or duplicated, except by flush or reset.
- Storage:
  - Main register holds the head entry, which drives the outputs.
  - Skid register exists only when SKID=1.
- Reset (`rst_n`=0 at an edge):
  - State becomes EMPTY.
  - `out_valid`=0, `out_ctrl`=0, `out_data`=0, `occupancy`=0.
  - Both registers are cleared to 0.
  - `in_ready` is 0 during reset and 1 in the first cycle after it.
- Flush (rst_n=1, flush=1):
  - Next state is EMPTY.
  - Any input presented in the same cycle is discarded, even if `in_ready`=1.
  - `out_data` keeps its last value; `out_ctrl` reads 0.
- Priority: reset > flush > normal transfer.
- SKID=1 state machine (`occupancy` equals the state index):
  - EMPTY (0):
    - `in_ready`=1.
    - in-fire -> ONE, main <= in.
  - ONE (1):
    - `in_ready`=1.
    - in-fire and out-fire -> ONE, main <= in.
    - in-fire only -> FULL, skid <= in.
    - out-fire only -> EMPTY.
    - Neither -> hold.
  - FULL (2):
    - `in_ready`=0.
    - out-fire -> ONE, main <= skid.
    - Otherwise hold.
  - `in_ready` is derived only from state (a registered signal). It has no combinational path from `out_ready`.
- SKID=0:
  - `in_ready` = `out_ready` | ~`out_valid` (combinational).
  - in-fire loads main.
  - out-fire without in-fire clears valid.
- Bubble rule: `out_ctrl` = main ctrl & {CTRL_W{`out_valid`}}. A stalled or flushed stage never asserts write enables downstream.
- Payload is stored bit-exact; no arithmetic is performed on it.

## Timing
- Latency: an entry in-fired at edge N appears on `out_*` in cycle N+1.
- Throughput: one entry per cycle sustained while `out_ready`=1, in both modes.
- SKID=1 back-pressure:
  - If `out_ready` drops in cycle N while ONE, an in-fire in N is absorbed into skid.
  - `in_ready` falls in cycle N+1.
  - When `out_ready` returns, the skid entry drains behind main in order.
  - `in_ready` rises in the cycle after FULL exits.
- Simultaneous events:
  - In FULL, `in_valid` is ignored (no in-fire).
  - Flush with out-fire in the same cycle: the head is consumed downstream this cycle, and the stage is EMPTY next cycle.
  - Reset mid-transfer: identical to reset from idle.
- Reset and flush both take effect at the edge where they are sampled. Outputs reflect them in the following cycle.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `in_valid`=1 and `in_ctrl`=4'hF -> `out_valid`=0, `out_ctrl`=0, `out_data`=0, `occupancy`=0. In the first cycle after release, `in_ready`=1.
- Streaming (SKID=1): 8 entries with data 1..8 and ctrl 4'h5, `out_ready`=1 throughout -> outputs 1..8 on consecutive cycles, each one cycle after its input. `occupancy` stays at 1 during the stream.
- Back-pressure: drop `out_ready` after entry 3 while continuing to present entries -> `occupancy` reaches 2 and `in_ready`=0. Raise `out_ready` after 4 cycles -> outputs in order 3,4,5,… with no loss or duplication.
- Flush in FULL: fill to occupancy 2, assert `flush` with `in_valid`=1 and data 9 -> next cycle `out_valid`=0, `out_ctrl`=0, `occupancy`=0, `in_ready`=1. Data 9 never appears on the output.
- Bubble masking: stall with valid head ctrl 4'hF, then out-fire with no new input -> `out_valid`=0 and `out_ctrl`=4'h0 on the next cycle. `out_data` holds its previous value.
- SKID=0 instance: `out_ready`=0 with head valid -> `in_ready`=0 in the same cycle. Set `out_ready`=1 with a new input -> pass-through at 1 entry/cycle, and `occupancy` never exceeds 1.

Source files
------------

// File: rtl/pipe_wall_elastic.sv
// pipe_wall_elastic: valid/ready pipeline wall with flush, bubble masking and optional two-entry skid buffer
module pipe_wall_elastic #(
  parameter int CTRL_W = 4,
  parameter int DATA_W = 133,
  parameter int SKID = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t state, state_nx;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  logic in_fire, out_fire, load_in, load_skid, push_skid;
  assign out_valid = state != EMPTY;
  assign in_ready = rst_n & ((SKID != 0) ? (state != FULL) : (out_ready | ~out_valid));
  assign in_fire = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign out_ctrl = main_ctrl & {CTRL_W{out_valid}};
  assign out_data = main_data;
  assign occupancy = state;
  // next state and register load selects; flush empties the stage and drops any input
  always_comb begin
    state_nx = state;
    load_in = 1'b0;
    load_skid = 1'b0;
    push_skid = 1'b0;
    case (state)
      EMPTY: begin
        state_nx = in_fire ? ONE : EMPTY;
        load_in = in_fire;
      end
      ONE: begin
        load_in = in_fire & (out_fire | (SKID == 0));
        push_skid = in_fire & ~out_fire & (SKID != 0);
        state_nx = push_skid ? FULL : (out_fire & ~in_fire) ? EMPTY : ONE;
      end
      FULL: begin
        state_nx = out_fire ? ONE : FULL;
        load_skid = out_fire;
      end
      default: state_nx = EMPTY;
    endcase
    if (flush) begin
      state_nx = EMPTY;
      load_in = 1'b0;
      load_skid = 1'b0;
      push_skid = 1'b0;
    end
  end
  // state, head and skid registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EMPTY;
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      state <= state_nx;
      if (load_in) begin
        main_ctrl <= in_ctrl;
        main_data <= in_data;
      end else if (load_skid) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end
      if (push_skid) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end
    end
  end
endmodule

// File: tb/tb_pipe_wall_elastic.sv
// tb_pipe_wall_elastic: directed plus random checks of both modes against a queue model
module tb_pipe_wall_elastic;
  localparam int CW = 4;
  localparam int DW = 133;
  typedef struct {logic [CW-1:0] c; logic [DW-1:0] d;} ent_t;
  logic clk = 1'b0;
  logic rst_n, flush, in_valid, out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic rdy1, ov1, rdy0, ov0;
  logic [CW-1:0] oc1, oc0;
  logic [DW-1:0] od1, od0;
  logic [1:0] occ1, occ0;
  ent_t q1[$], q0[$];
  logic [DW-1:0] md1, md0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  pipe_wall_elastic #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov1), .out_ready(out_ready),
    .out_ctrl(oc1), .out_data(od1), .occupancy(occ1));
  pipe_wall_elastic #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy0),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov0), .out_ready(out_ready),
    .out_ctrl(oc0), .out_data(od0), .occupancy(occ0));
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    logic er1, er0, fi1, fo1, fi0, fo0;
    @(negedge clk);
    er1 = rst_n && q1.size() < 2;
    er0 = rst_n && (q0.size() == 0 || out_ready);
    chk("skid_in_ready", rdy1, er1);
    chk("skid_out_valid", ov1, q1.size() > 0);
    chk("skid_out_ctrl", oc1, q1.size() > 0 ? q1[0].c : '0);
    chk("skid_out_data", od1, md1);
    chk("skid_occupancy", occ1, q1.size());
    chk("reg_in_ready", rdy0, er0);
    chk("reg_out_valid", ov0, q0.size() > 0);
    chk("reg_out_ctrl", oc0, q0.size() > 0 ? q0[0].c : '0);
    chk("reg_out_data", od0, md0);
    chk("reg_occupancy", occ0, q0.size());
    fi1 = in_valid && er1;
    fo1 = out_ready && q1.size() > 0;
    fi0 = in_valid && er0;
    fo0 = out_ready && q0.size() > 0;
    @(posedge clk);
    if (!rst_n) begin
      q1.delete(); q0.delete(); md1 = '0; md0 = '0;
    end else if (flush) begin
      q1.delete(); q0.delete();
    end else begin
      if (fo1) void'(q1.pop_front());
      if (fi1) q1.push_back('{in_ctrl, in_data});
      if (fo0) void'(q0.pop_front());
      if (fi0) q0.push_back('{in_ctrl, in_data});
    end
    if (q1.size() > 0) md1 = q1[0].d;
    if (q0.size() > 0) md0 = q0[0].d;
    #1;
  endtask
  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d, input logic r, input logic f);
    in_valid = v; in_ctrl = c; in_data = d; out_ready = r; flush = f;
    step();
  endtask
  initial begin
    md1 = '0; md0 = '0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_ctrl = 4'hF; in_data = 133'h1234; out_ready = 1'b1;
    @(posedge clk); #1;
    step();
    rst_n = 1'b1;
    drive(0, 0, 0, 1, 0);
    for (int i = 1; i <= 8; i++) drive(1, 4'h5, DW'(i), 1, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    for (int i = 1; i <= 3; i++) drive(1, 4'h5, DW'(i), 1, 0);
    for (int i = 4; i <= 7; i++) drive(1, 4'h5, DW'(i), 0, 0);
    for (int i = 8; i <= 10; i++) drive(1, 4'h5, DW'(i), 1, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 0);
    drive(1, 4'h3, 133'h11, 0, 0);
    drive(1, 4'h3, 133'h22, 0, 0);
    drive(1, 4'h3, 133'h9, 0, 1);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    drive(1, 4'hF, 133'hABCDE, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    drive(1, 4'h6, 133'h77, 1, 0);
    drive(0, 0, 0, 1, 1);
    drive(0, 0, 0, 1, 0);
    drive(1, 4'h2, 133'h5, 0, 0);
    drive(1, 4'h2, 133'h6, 0, 0);
    rst_n = 1'b0;
    drive(1, 4'hF, 133'h7, 1, 0);
    rst_n = 1'b1;
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 400; i++) begin
      rst_n = $urandom_range(0, 59) != 0;
      drive($urandom_range(0, 3) != 0, CW'($urandom),
            DW'({$urandom, $urandom, $urandom, $urandom, $urandom}),
            $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
